// File: rtl/dct8_stream_if.sv
`timescale 1ns/1ps
// Sample-in / coefficient-out handshake bundle for the streaming 8-point DCT.
// The master side is the producer of samples and the consumer of coefficients.
interface dct8_stream_if #(
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned DOUT_W = 12
) ();
    logic                     s_valid;
    logic                     s_ready;
    logic [DIN_W-1:0]         s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DOUT_W-1:0] m_data;
    logic [2:0]               m_index;
    logic                     m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_index, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_index, m_last
    );
endinterface

// File: rtl/dct8_stream.sv
`timescale 1ns/1ps
// Streaming 8-point forward DCT: gathers 8 samples, transforms them in one
// cycle into a coefficient buffer and drains y0..y7, while the next block fills.
module dct8_stream #(
    parameter int unsigned DIN_W       = 8,
    parameter int unsigned SIGNED_IN   = 0,
    parameter int unsigned LEVEL_SHIFT = 1,
    parameter int unsigned DOUT_W      = 12,
    parameter int unsigned COEF_W      = 16
) (
    input logic          clk,
    input logic          reset,
    dct8_stream_if.slave bus
);
    localparam int unsigned ACC_W = DIN_W + COEF_W + 4;

    // Q15 cos(k*pi/16)
    localparam logic signed [ACC_W-1:0] CA = ACC_W'(32'h5A82);
    localparam logic signed [ACC_W-1:0] CB = ACC_W'(32'h7D8A);
    localparam logic signed [ACC_W-1:0] CC = ACC_W'(32'h7642);
    localparam logic signed [ACC_W-1:0] CD = ACC_W'(32'h6A6E);
    localparam logic signed [ACC_W-1:0] CE = ACC_W'(32'h471D);
    localparam logic signed [ACC_W-1:0] CF = ACC_W'(32'h30FC);
    localparam logic signed [ACC_W-1:0] CG = ACC_W'(32'h18F9);

    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(32'h8000);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DOUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DIN_W:0]   SHIFT   = {2'b01, {(DIN_W - 1){1'b0}}};

    logic [3:0]               in_cnt_q, in_cnt_d, in_base;
    logic signed [DIN_W:0]    in_buf_q [8];
    logic signed [DIN_W:0]    in_buf_d [8];
    logic signed [DOUT_W-1:0] out_buf_q [8];
    logic signed [DOUT_W-1:0] out_buf_d [8];
    logic                     out_full_q, out_full_d;
    logic [2:0]               out_idx_q, out_idx_d;

    logic                     in_full, last_hs, xfer, s_hs;
    logic signed [DIN_W:0]    x_in;
    logic signed [ACC_W-1:0]  xe [8];
    logic signed [ACC_W-1:0]  t [4];
    logic signed [ACC_W-1:0]  c [4];
    logic signed [ACC_W-1:0]  acc [8];
    logic signed [ACC_W-1:0]  rnd [8];
    logic signed [DOUT_W-1:0] coef [8];

    // Condition the incoming sample to DIN_W+1 signed, optionally level-shifted.
    always_comb begin
        x_in = (SIGNED_IN != 0) ? {bus.s_data[DIN_W-1], bus.s_data} : {1'b0, bus.s_data};
        if (LEVEL_SHIFT != 0) begin
            x_in = x_in - SHIFT;
        end
    end

    // Handshake decode; a full input block moves over when the output buffer
    // is empty or its last coefficient leaves on this same edge.
    always_comb begin
        in_full = (in_cnt_q == 4'd8);
        last_hs = out_full_q && bus.m_ready && (out_idx_q == 3'd7);
        xfer    = in_full && (!out_full_q || last_hs);
        s_hs    = bus.s_valid && (!in_full || xfer);
    end

    // Butterfly and coefficient products, all at accumulator width.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            xe[i] = ACC_W'(in_buf_q[i]);
        end
        for (int i = 0; i < 4; i++) begin
            t[i] = xe[i] + xe[7-i];
            c[i] = xe[i] - xe[7-i];
        end
        acc[0] = CA * (t[0] + t[1] + t[2] + t[3]);
        acc[4] = CA * (t[0] + t[3] - t[1] - t[2]);
        acc[2] = CC * (t[0] - t[3]) + CF * (t[1] - t[2]);
        acc[6] = CF * (t[0] - t[3]) + CC * (t[2] - t[1]);
        acc[1] = CB * c[0] + CD * c[1] + CE * c[2] + CG * c[3];
        acc[3] = CD * c[0] - CG * c[1] - CB * c[2] - CE * c[3];
        acc[5] = CE * c[0] - CB * c[1] + CG * c[2] + CD * c[3];
        acc[7] = CG * c[0] - CE * c[1] + CD * c[2] - CB * c[3];
    end

    // Round to nearest (Q15 plus the 0.5 orthonormal factor) and saturate.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            rnd[k] = (acc[k] + ROUND) >>> 16;
            if (rnd[k] > SAT_MAX) begin
                coef[k] = SAT_MAX[DOUT_W-1:0];
            end else if (rnd[k] < SAT_MIN) begin
                coef[k] = SAT_MIN[DOUT_W-1:0];
            end else begin
                coef[k] = rnd[k][DOUT_W-1:0];
            end
        end
    end

    // Next state: the transfer cycle frees the input buffer, so x0 of the
    // following block lands in entry 0 on the same edge.
    always_comb begin
        in_base   = xfer ? 4'd0 : in_cnt_q;
        in_cnt_d  = in_base;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        out_full_d = out_full_q;
        out_idx_d = out_idx_q;
        if (s_hs) begin
            in_buf_d[in_base[2:0]] = x_in;
            in_cnt_d = in_base + 4'd1;
        end
        if (xfer) begin
            out_buf_d  = coef;
            out_full_d = 1'b1;
            out_idx_d  = 3'd0;
        end else if (out_full_q && bus.m_ready) begin
            out_idx_d = out_idx_q + 3'd1;
            if (out_idx_q == 3'd7) begin
                out_full_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q   <= 4'd0;
            in_buf_q   <= '{default: '0};
            out_buf_q  <= '{default: '0};
            out_full_q <= 1'b0;
            out_idx_q  <= 3'd0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            in_buf_q   <= in_buf_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // Output drive straight from the registered buffer and index.
    always_comb begin
        bus.s_ready = !in_full || xfer;
        bus.m_valid = out_full_q;
        bus.m_data  = out_buf_q[out_idx_q];
        bus.m_index = out_idx_q;
        bus.m_last  = (out_idx_q == 3'd7);
    end
endmodule

// File: tb/tb_dct8_stream.sv
`timescale 1ns/1ps
// Directed bench for dct8_stream: default build plus LEVEL_SHIFT=0 and DOUT_W=8 builds.
module tb_dct8_stream;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dct8_stream_if #(.DIN_W(8), .DOUT_W(12)) bus ();
    dct8_stream_if #(.DIN_W(8), .DOUT_W(12)) bus_ns ();
    dct8_stream_if #(.DIN_W(8), .DOUT_W(8))  bus_w8 ();

    dct8_stream u_dut (.clk(clk), .reset(reset), .bus(bus));
    dct8_stream #(.LEVEL_SHIFT(0)) u_dut_ns (.clk(clk), .reset(reset), .bus(bus_ns));
    dct8_stream #(.DOUT_W(8)) u_dut_w8 (.clk(clk), .reset(reset), .bus(bus_w8));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]         in_q [$];
    logic signed [11:0] out_d [$];
    logic [2:0]         out_i [$];
    logic               out_l [$];
    int                 out_cyc [$];
    int                 exp_q [$];
    int                 sready_drops;

    task automatic clear_q();
        in_q.delete();
        out_d.delete();
        out_i.delete();
        out_l.delete();
        out_cyc.delete();
        exp_q.delete();
        sready_drops = 0;
    endtask

    task automatic push_const(input logic [7:0] v);
        for (int i = 0; i < 8; i++) in_q.push_back(v);
    endtask

    // 0,32,...,224 -> level-shifted -128..96
    task automatic push_ramp();
        for (int i = 0; i < 8; i++) in_q.push_back(8'(32 * i));
    endtask

    task automatic exp8(input int y0, input int y1, input int y2, input int y3,
                        input int y4, input int y5, input int y6, input int y7);
        exp_q.push_back(y0); exp_q.push_back(y1); exp_q.push_back(y2); exp_q.push_back(y3);
        exp_q.push_back(y4); exp_q.push_back(y5); exp_q.push_back(y6); exp_q.push_back(y7);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Feed n_in samples from in_q with m_ready=1 until n_out coefficients are
    // collected or the cycle budget runs out. Enters/leaves 1 ns after posedge.
    task automatic stream(input int n_in, input int n_out, input int budget);
        int sent = 0;
        int cyc  = 0;
        while ((sent < n_in || out_d.size() < n_out) && cyc < budget) begin
            bus.s_valid = (sent < n_in);
            bus.s_data  = (sent < n_in) ? in_q[sent] : 8'd0;
            bus.m_ready = 1'b1;
            @(negedge clk);
            if (bus.m_valid && out_d.size() < n_out) begin
                out_d.push_back(bus.m_data);
                out_i.push_back(bus.m_index);
                out_l.push_back(bus.m_last);
                out_cyc.push_back(cyc);
            end
            if (sent < n_in && !bus.s_ready) sready_drops++;
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got %b want 1", bus.s_ready); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b want 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 12'sd0) begin n_fail++; $display("FAIL rst_m_data got %0d want 0", bus.m_data); end
        n_checks++; if (bus.m_index !== 3'd0) begin n_fail++; $display("FAIL rst_m_index got %0d want 0", bus.m_index); end
        n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got %b want 0", bus.m_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_gray();
        do_reset();
        clear_q();
        push_const(8'd128);
        stream(8, 8, 40);
        n_checks++; if (out_d.size() != 8) begin n_fail++; $display("FAIL gray_count got %0d want 8", out_d.size()); end
        for (int k = 0; k < out_d.size(); k++) begin
            n_checks++; if (out_d[k] !== 12'sd0) begin n_fail++; $display("FAIL gray_y%0d got %0d want 0", k, out_d[k]); end
            n_checks++; if (out_i[k] !== 3'(k)) begin n_fail++; $display("FAIL gray_index%0d got %0d want %0d", k, out_i[k], k); end
            n_checks++; if (out_l[k] !== (k == 7)) begin n_fail++; $display("FAIL gray_last%0d got %b want %b", k, out_l[k], k == 7); end
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        clear_q();
        push_const(8'd255);
        push_const(8'd0);
        exp8(359, 0, 0, 0, 0, 0, 0, 0);
        exp8(-362, 0, 0, 0, 0, 0, 0, 0);
        stream(16, 16, 60);
        n_checks++; if (out_d.size() != 16) begin n_fail++; $display("FAIL scale_count got %0d want 16", out_d.size()); end
        for (int k = 0; k < out_d.size(); k++) begin
            n_checks++; if (out_d[k] !== exp_q[k]) begin n_fail++; $display("FAIL scale_y%0d got %0d want %0d", k, out_d[k], exp_q[k]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_q();
        push_const(8'd128); exp8(0, 0, 0, 0, 0, 0, 0, 0);
        push_const(8'd255); exp8(359, 0, 0, 0, 0, 0, 0, 0);
        push_const(8'd0);   exp8(-362, 0, 0, 0, 0, 0, 0, 0);
        push_ramp();        exp8(-45, -206, 0, -22, 0, -6, 0, -2);
        stream(32, 32, 120);
        n_checks++; if (out_d.size() != 32) begin n_fail++; $display("FAIL b2b_count got %0d want 32", out_d.size()); end
        n_checks++; if (sready_drops != 0) begin n_fail++; $display("FAIL b2b_s_ready_drops got %0d want 0", sready_drops); end
        if (out_d.size() == 32) begin
            n_checks++; if (out_cyc[0] != 9) begin n_fail++; $display("FAIL b2b_latency got cycle %0d want 9", out_cyc[0]); end
            n_checks++; if (out_cyc[31] - out_cyc[0] != 31) begin n_fail++; $display("FAIL b2b_span got %0d want 31", out_cyc[31] - out_cyc[0]); end
        end
        for (int k = 0; k < out_d.size(); k++) begin
            n_checks++; if (out_d[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_y%0d got %0d want %0d", k, out_d[k], exp_q[k]); end
            n_checks++; if (out_i[k] !== 3'(k % 8)) begin n_fail++; $display("FAIL b2b_index%0d got %0d want %0d", k, out_i[k], k % 8); end
        end
    endtask

    task automatic test_backpressure();
        int sent  = 0;
        int stall = 0;
        int cyc   = 0;
        do_reset();
        clear_q();
        push_ramp();        exp8(-45, -206, 0, -22, 0, -6, 0, -2);
        push_const(8'd255); exp8(359, 0, 0, 0, 0, 0, 0, 0);
        while (out_d.size() < 16 && cyc < 200) begin
            bus.s_valid = (sent < 16);
            bus.s_data  = (sent < 16) ? in_q[sent] : 8'd0;
            bus.m_ready = !(out_d.size() == 3 && stall < 20);
            @(negedge clk);
            if (!bus.m_ready) begin
                stall++;
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 12'sd0 - 12'sd22 || bus.m_index !== 3'd3) begin
                    n_fail++;
                    $display("FAIL bp_hold cycle %0d got valid=%b data=%0d idx=%0d want 1/-22/3",
                             stall, bus.m_valid, bus.m_data, bus.m_index);
                end
                if (stall == 20) begin
                    n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready got %b want 0", bus.s_ready); end
                    n_checks++; if (sent != 16) begin n_fail++; $display("FAIL bp_sent got %0d want 16", sent); end
                end
            end else if (bus.m_valid) begin
                out_d.push_back(bus.m_data);
                out_i.push_back(bus.m_index);
            end
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        n_checks++; if (out_d.size() != 16) begin n_fail++; $display("FAIL bp_count got %0d want 16", out_d.size()); end
        for (int k = 0; k < out_d.size(); k++) begin
            n_checks++; if (out_d[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_y%0d got %0d want %0d", k, out_d[k], exp_q[k]); end
            n_checks++; if (out_i[k] !== 3'(k % 8)) begin n_fail++; $display("FAIL bp_index%0d got %0d want %0d", k, out_i[k], k % 8); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_q();
        push_const(8'd255);
        stream(5, 0, 20);
        do_reset();
        // A fresh block must line up from x0 with no leftover samples.
        clear_q();
        push_ramp();
        exp8(-45, -206, 0, -22, 0, -6, 0, -2);
        stream(8, 3, 40);
        n_checks++; if (out_d.size() != 3) begin n_fail++; $display("FAIL rmid_count got %0d want 3", out_d.size()); end
        for (int k = 0; k < out_d.size(); k++) begin
            n_checks++; if (out_d[k] !== exp_q[k]) begin n_fail++; $display("FAIL rmid_y%0d got %0d want %0d", k, out_d[k], exp_q[k]); end
        end
        @(negedge clk);
        n_checks++; if (bus.m_data !== 12'sd0 - 12'sd22) begin n_fail++; $display("FAIL rmid_pre_y3 got %0d want -22", bus.m_data); end
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid got %b want 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 12'sd0) begin n_fail++; $display("FAIL rmid_m_data got %0d want 0", bus.m_data); end
        n_checks++; if (bus.m_index !== 3'd0) begin n_fail++; $display("FAIL rmid_m_index got %0d want 0", bus.m_index); end
        n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rmid_m_last got %b want 0", bus.m_last); end
        n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_s_ready got %b want 1", bus.s_ready); end
        @(posedge clk); #1;
        clear_q();
        push_ramp();
        exp8(-45, -206, 0, -22, 0, -6, 0, -2);
        stream(8, 8, 40);
        n_checks++; if (out_d.size() != 8) begin n_fail++; $display("FAIL rpost_count got %0d want 8", out_d.size()); end
        for (int k = 0; k < out_d.size(); k++) begin
            n_checks++; if (out_d[k] !== exp_q[k]) begin n_fail++; $display("FAIL rpost_y%0d got %0d want %0d", k, out_d[k], exp_q[k]); end
            n_checks++; if (out_i[k] !== 3'(k)) begin n_fail++; $display("FAIL rpost_index%0d got %0d want %0d", k, out_i[k], k); end
        end
    endtask

    // LEVEL_SHIFT=0, x_n = n
    task automatic test_no_shift();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int exp_ns [8] = '{10, -6, 0, -1, 0, 0, 0, 0};
        do_reset();
        while (got < 8 && cyc < 40) begin
            bus_ns.s_valid = (sent < 8);
            bus_ns.s_data  = 8'(sent);
            bus_ns.m_ready = 1'b1;
            @(negedge clk);
            if (bus_ns.m_valid) begin
                n_checks++;
                if (bus_ns.m_data !== exp_ns[got] || bus_ns.m_index !== 3'(got)) begin
                    n_fail++;
                    $display("FAIL noshift_y%0d got %0d idx %0d want %0d idx %0d",
                             got, bus_ns.m_data, bus_ns.m_index, exp_ns[got], got);
                end
                got++;
            end
            if (bus_ns.s_valid && bus_ns.s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus_ns.s_valid = 1'b0;
        bus_ns.m_ready = 1'b0;
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL noshift_count got %0d want 8", got); end
    endtask

    // DOUT_W=8: 8x255 then 8x0 saturate y0 to +127 and -128.
    task automatic test_saturate();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int exp_w;
        do_reset();
        while (got < 16 && cyc < 60) begin
            bus_w8.s_valid = (sent < 16);
            bus_w8.s_data  = (sent < 8) ? 8'd255 : 8'd0;
            bus_w8.m_ready = 1'b1;
            @(negedge clk);
            if (bus_w8.m_valid) begin
                exp_w = (got == 0) ? 127 : (got == 8) ? -128 : 0;
                n_checks++;
                if (bus_w8.m_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL sat_y%0d got %0d want %0d", got, bus_w8.m_data, exp_w);
                end
                got++;
            end
            if (bus_w8.s_valid && bus_w8.s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus_w8.s_valid = 1'b0;
        bus_w8.m_ready = 1'b0;
        n_checks++; if (got != 16) begin n_fail++; $display("FAIL sat_count got %0d want 16", got); end
    endtask

    initial begin
        reset = 1'b1;
        bus.s_valid = 1'b0;    bus.s_data = 8'd0;    bus.m_ready = 1'b0;
        bus_ns.s_valid = 1'b0; bus_ns.s_data = 8'd0; bus_ns.m_ready = 1'b0;
        bus_w8.s_valid = 1'b0; bus_w8.s_data = 8'd0; bus_w8.m_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_mid_gray();
        test_full_scale();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_no_shift();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
